redmule_tcdm_responder: RTL and testbench
=========================================

// Module: redmule_tcdm_responder
// PURPOSE
// Responder (memory) end of the RedMulE wide TCDM data port. Accepts
// redmule_default_data_req_t beats, grants them, services reads/writes on an
// internal 32-bit word array, and returns redmule_default_data_rsp_t with fixed
// latency and lrdy back-pressure. Used as the TCDM model in block benches, with
// optional grant-stall injection to stress streamers.
// PARAMETERS
// MEM_WORDS   4096  depth of word array (32-bit words), power of 2
// LATENCY     1     cycles from granted read to earliest r_valid (>=1)
// FIFO_DEPTH  4     max outstanding reads (pipeline + response FIFO), >=LATENCY
// STALL_SEED  16'hACE1  LFSR seed for grant-stall injection
// PORTS
// clk_i      in   1          clock
// rst_ni     in   1          async active-low reset
// clear_i    in   1          sync clear: flush pipeline/FIFO, reset LFSR (memory kept)
// stall_en_i in   1          enable pseudo-random grant stalls
// tcdm_req_i in   req_t      redmule_default_data_req_t (req,wen,be,boffs,add,data,lrdy,user)
// tcdm_rsp_o out  rsp_t      redmule_default_data_rsp_t (gnt,r_valid,r_data,r_opc,r_user)
// BEHAVIOUR
// - Reset: gnt=0, r_valid=0, r_data=0, r_opc=0, r_user=0; outstanding=0; LFSR=STALL_SEED.
//   Memory contents undefined after reset (not cleared).
// - Words per beat NW=DATA_W/32. Word i byte address = add + 4*i + boffs[i]; word
//   index = addr[31:2] (addr[1:0] ignored). Index >= MEM_WORDS -> out of range.
// - gnt (combinational) = req & (outstanding < FIFO_DEPTH) & ~(stall_en_i & lfsr[1:0]==2'b00).
//   gnt independent of lrdy except via outstanding. LFSR (x^16+x^14+x^13+x^11) steps every cycle.
// - Handshake: transfer on req&gnt. wen=0 -> write; wen=1 -> read (HCI convention).
// - Write: at transfer edge, byte b of word i written iff be[4*i+b] and word in range.
//   No response generated for writes. Out-of-range write bytes dropped silently.
// - Read: data sampled at transfer edge (sees all writes transferred in earlier cycles);
//   out-of-range words read as 0 and set r_opc=1 for that response. r_user echoes user.
// - Latency: read enters a LATENCY-1 stage shift pipeline, then response FIFO. r_valid
//   asserted from FIFO head; earliest r_valid at transfer cycle + LATENCY when FIFO empty.
//   Pop on r_valid & lrdy; r_data/r_opc/r_user held stable while r_valid & ~lrdy.
// - outstanding: +1 on read transfer, -1 on pop; simultaneous +1/-1 -> unchanged.
//   Never exceeds FIFO_DEPTH so FIFO never overflows; responses stay in request order.
// - clear_i: outstanding=0, pipeline/FIFO emptied, r_valid=0 next cycle, LFSR reseeded;
//   a request presented in the clear cycle is not granted.
// - Async reset mid-transaction discards all in-flight reads; no response emitted.
// STRUCTURE
// - redmule_pkg additions: typedef tcdm_rsp_entry_t {logic [DATA_W-1:0] data; logic opc;
//   logic user;}; localparam TCDM_NW = DATA_W/32.
// - One sub-module: redmule_tcdm_rsp_fifo (FIFO_DEPTH entries of tcdm_rsp_entry_t,
//   push/pop/full/empty, clear). Memory array, LFSR, pipeline, counter inline.
// TESTING
// - Write add=0x100, be=all-1, data=pattern; read add=0x100 next cycle, lrdy=1,
//   LATENCY=1 -> r_valid one cycle after gnt, r_data=pattern, r_opc=0.
// - Partial write be=32'h0000000F data=0xDEADBEEF over prefilled 0x0 -> read returns
//   word0=0xDEADBEEF, other words 0.
// - lrdy=0, 5 back-to-back reads, FIFO_DEPTH=4 -> exactly 4 gnt, 5th held low; raise
//   lrdy -> 4 responses in order, then 5th granted.
// - Read add=(MEM_WORDS*4-8) with NW=8 -> words 0,1 valid, words 2..7 =0, r_opc=1;
//   write same address leaves in-range words updated only.
// - boffs[3]=+32 -> word3 served from add+12+32; matches scoreboard.
// - stall_en_i=1, 1000 random reads/writes -> gnt dropped on LFSR pattern, no lost/
//   reordered responses; assert clear_i mid-stream -> r_valid=0, outstanding=0.

Source files
------------

// File: rtl/redmule_tcdm_responder_pkg.sv
// Shared types for the RedMulE TCDM responder model.
//   - redmule_default_data_req_t / _rsp_t : wide TCDM data port beats.
//   - tcdm_rsp_entry_t : one queued read response (data, error flag, user echo).
//   - word_index()     : 30-bit word index of word i of a beat.
package redmule_tcdm_responder_pkg;

    localparam int unsigned DATA_W  = 256;
    localparam int unsigned TCDM_NW = DATA_W / 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned BOFFS_W = 8;

    typedef struct packed {
        logic                              req;
        logic                              wen;    // 1 = read, 0 = write
        logic [BE_W-1:0]                   be;
        logic [TCDM_NW-1:0][BOFFS_W-1:0]   boffs;  // per-word byte offset
        logic [31:0]                       add;
        logic [DATA_W-1:0]                 data;
        logic                              lrdy;
        logic                              user;
    } redmule_default_data_req_t;

    typedef struct packed {
        logic              gnt;
        logic              r_valid;
        logic [DATA_W-1:0] r_data;
        logic              r_opc;
        logic              r_user;
    } redmule_default_data_rsp_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              opc;
        logic              user;
    } tcdm_rsp_entry_t;

    // Byte address of word i is add + 4*i + boffs; the two LSBs are dropped.
    function automatic logic [29:0] word_index(input logic [31:0]        add,
                                               input int unsigned        i,
                                               input logic [BOFFS_W-1:0] boffs);
        return 30'((add + 32'(4 * i) + 32'(boffs)) >> 2);
    endfunction

endpackage

// File: rtl/redmule_tcdm_responder_rsp_fifo.sv
// Response FIFO for the TCDM responder.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous flush
//   push/wdata : enqueue (ignored when full)
//   pop/rdata  : dequeue; rdata is the head entry
//   full/empty : occupancy flags
module redmule_tcdm_rsp_fifo
    import redmule_tcdm_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  tcdm_rsp_entry_t wdata,
    input  logic            pop,
    output tcdm_rsp_entry_t rdata,
    output logic            full,
    output logic            empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    tcdm_rsp_entry_t  store [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = store[rptr];

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) store[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= nxt(wptr);
            if (do_pop)  rptr <= nxt(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Memory-side model of the RedMulE wide TCDM data port.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : flush in-flight reads and reseed the stall LFSR (memory kept)
//   stall_en_i    : enable pseudo-random grant stalls
//   tcdm_req_i    : request beat (req, wen, be, boffs, add, data, lrdy, user)
//   tcdm_rsp_o    : gnt (combinational), r_valid/r_data/r_opc/r_user from FIFO head
// Reads travel through LATENCY-1 register stages into the response FIFO, so the
// earliest r_valid is LATENCY cycles after the granted read.
module redmule_tcdm_responder
    import redmule_tcdm_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      stall_en_i,
    input  redmule_default_data_req_t tcdm_req_i,
    output redmule_default_data_rsp_t tcdm_rsp_o
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned STAGES = LATENCY - 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [31:0]               mem [MEM_WORDS];
    logic [15:0]               lfsr;
    logic [CNT_W-1:0]          outstanding;
    logic [TCDM_NW-1:0][29:0]  widx;
    logic [TCDM_NW-1:0]        in_range;
    logic                      stall, gnt, rd_xfer, wr_xfer, pop;
    logic                      fifo_push, fifo_full, fifo_empty;
    tcdm_rsp_entry_t           rd_entry, fifo_wdata, head;

    // ---------------- address decode ----------------
    for (genvar i = 0; i < TCDM_NW; i++) begin : g_addr
        assign widx[i]     = word_index(tcdm_req_i.add, i, tcdm_req_i.boffs[i]);
        assign in_range[i] = (widx[i] < 30'(MEM_WORDS));
    end

    // ---------------- handshake ----------------
    assign stall   = stall_en_i & (lfsr[1:0] == 2'b00);
    // fifo_full is implied by the outstanding limit; kept as a second guard.
    assign gnt     = tcdm_req_i.req & ~clear_i & ~stall & ~fifo_full
                   & (outstanding < CNT_W'(FIFO_DEPTH));
    assign rd_xfer = gnt & tcdm_req_i.wen;
    assign wr_xfer = gnt & ~tcdm_req_i.wen;
    assign pop     = ~fifo_empty & tcdm_req_i.lrdy;

    // x^16+x^14+x^13+x^11, right-shifting Fibonacci form.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      lfsr <= STALL_SEED;
        else if (clear_i) lfsr <= STALL_SEED;
        else              lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    // Counts reads in the pipeline plus the FIFO, so the FIFO can never overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      outstanding <= '0;
        else if (clear_i) outstanding <= '0;
        else begin
            case ({rd_xfer, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ---------------- memory ----------------
    // Contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_xfer) begin
            for (int i = 0; i < TCDM_NW; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (tcdm_req_i.be[4*i+b] && in_range[i])
                        mem[widx[i][IDX_W-1:0]][8*b +: 8] <= tcdm_req_i.data[32*i+8*b +: 8];
                end
            end
        end
    end

    // Read data is taken before this edge's update; a beat is never both read and write.
    always_comb begin
        rd_entry      = '0;
        rd_entry.user = tcdm_req_i.user;
        for (int i = 0; i < TCDM_NW; i++) begin
            if (in_range[i]) rd_entry.data[32*i +: 32] = mem[widx[i][IDX_W-1:0]];
            else             rd_entry.opc = 1'b1;
        end
    end

    // ---------------- latency pipeline ----------------
    if (STAGES == 0) begin : g_nopipe
        assign fifo_push  = rd_xfer;
        assign fifo_wdata = rd_entry;
    end else begin : g_pipe
        logic [STAGES:1] vld_pipe;
        tcdm_rsp_entry_t ent_pipe [STAGES:1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_pipe <= '0;
                for (int s = 1; s <= STAGES; s++) ent_pipe[s] <= '0;
            end else if (clear_i) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[1] <= rd_xfer;
                ent_pipe[1] <= rd_entry;
                for (int s = 2; s <= STAGES; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    ent_pipe[s] <= ent_pipe[s-1];
                end
            end
        end

        assign fifo_push  = vld_pipe[STAGES];
        assign fifo_wdata = ent_pipe[STAGES];
    end

    redmule_tcdm_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) i_rsp_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (clear_i),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Response fields read as zero whenever no response is presented.
    always_comb begin
        tcdm_rsp_o         = '0;
        tcdm_rsp_o.gnt     = gnt;
        tcdm_rsp_o.r_valid = ~fifo_empty;
        if (!fifo_empty) begin
            tcdm_rsp_o.r_data = head.data;
            tcdm_rsp_o.r_opc  = head.opc;
            tcdm_rsp_o.r_user = head.user;
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
module tb_redmule_tcdm_responder;
    import redmule_tcdm_responder_pkg::*;

    localparam int          MEMW  = 4096;
    localparam int          DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, stall_en = 1'b0;
    redmule_default_data_req_t req;
    redmule_default_data_rsp_t rsp;

    always #5 clk = ~clk;

    redmule_tcdm_responder #(
        .MEM_WORDS(MEMW), .LATENCY(1), .FIFO_DEPTH(DEPTH), .STALL_SEED(SEED)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_en_i(stall_en),
        .tcdm_req_i(req), .tcdm_rsp_o(rsp)
    );

    // Reference model: byte-exact word array, ordered queue of expected
    // responses stamped with the cycle they may first appear, and the stall LFSR.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              opc;
        logic              user;
        int                rdy;
    } exp_t;

    exp_t              q[$];
    logic [31:0]       mm [MEMW];
    int unsigned       lfsr;
    int                cyc, total, bad;
    logic              got_gnt, popped;
    logic [DATA_W-1:0] pop_data;
    logic              pop_opc;

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic checkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned waddr(input int i);
        logic [31:0] a;
        a = req.add + 32'(4 * i) + {24'b0, req.boffs[i]};
        return int'(a >> 2);
    endfunction

    function automatic void model_write();
        for (int i = 0; i < TCDM_NW; i++) begin
            int unsigned w = waddr(i);
            if (w < MEMW)
                for (int b = 0; b < 4; b++)
                    if (req.be[4*i+b]) mm[w][8*b +: 8] = req.data[32*i+8*b +: 8];
        end
    endfunction

    function automatic exp_t model_read();
        exp_t e;
        e.data = '0;
        e.opc  = 1'b0;
        e.user = req.user;
        e.rdy  = cyc + 1;
        for (int i = 0; i < TCDM_NW; i++) begin
            int unsigned w = waddr(i);
            if (w < MEMW) e.data[32*i +: 32] = mm[w];
            else          e.opc = 1'b1;
        end
        return e;
    endfunction

    // One clock: compare at negedge, advance the model, move past the posedge.
    task automatic step();
        logic eg, ev;
        int unsigned fb;
        @(negedge clk);
        eg = req.req && !clear && (q.size() < DEPTH) && !(stall_en && ((lfsr & 3) == 0));
        ev = (q.size() > 0) && (q[0].rdy <= cyc);
        check1("gnt", rsp.gnt, eg);
        check1("r_valid", rsp.r_valid, ev);
        if (ev) begin
            checkd("r_data", rsp.r_data, q[0].data);
            check1("r_opc", rsp.r_opc, q[0].opc);
            check1("r_user", rsp.r_user, q[0].user);
        end
        got_gnt = rsp.gnt;
        popped  = 1'b0;
        if (clear) begin
            q.delete();
            lfsr = SEED;
        end else begin
            if (ev && req.lrdy) begin
                popped   = 1'b1;
                pop_data = rsp.r_data;
                pop_opc  = rsp.r_opc;
                void'(q.pop_front());
            end
            if (eg) begin
                if (!req.wen) model_write();
                else          q.push_back(model_read());
            end
            fb   = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
            lfsr = (lfsr >> 1) | (fb << 15);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < TCDM_NW; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    logic [DATA_W-1:0] pat, w2;
    int k, npop;

    initial begin
        total = 0; bad = 0; cyc = 0; lfsr = SEED;
        req = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_gnt", rsp.gnt, 1'b0);
        check1("rst_r_valid", rsp.r_valid, 1'b0);
        checkd("rst_r_data", rsp.r_data, '0);
        check1("rst_r_opc", rsp.r_opc, 1'b0);
        check1("rst_r_user", rsp.r_user, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        lfsr = SEED;

        // prefill whole memory with zeros
        for (int w = 0; w < MEMW / TCDM_NW; w++) begin
            req = '0; req.req = 1'b1; req.be = '1; req.lrdy = 1'b1;
            req.add = 32'(w * 32);
            step();
        end

        // full write then read-back, LATENCY 1
        for (int i = 0; i < TCDM_NW; i++) pat[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        req = '0; req.req = 1'b1; req.be = '1; req.add = 32'h100; req.data = pat; req.lrdy = 1'b1;
        step();
        req.wen = 1'b1; req.user = 1'b1;
        step();
        req.req = 1'b0;
        step();
        check1("rd1_popped", popped, 1'b1);
        checkd("rd1_data", pop_data, pat);

        // partial write keeps other bytes at zero
        req = '0; req.req = 1'b1; req.be = 32'h0000_000F; req.add = 32'h200; req.lrdy = 1'b1;
        req.data = {rnd_data() >> 32, 32'hDEAD_BEEF};
        step();
        req.wen = 1'b1; req.be = '0;
        step();
        req.req = 1'b0;
        step();
        checkd("partial_data", pop_data, {{(DATA_W-32){1'b0}}, 32'hDEAD_BEEF});

        // back-pressure: 5 reads, lrdy low
        req = '0; req.wen = 1'b1; req.lrdy = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            req.req = 1'b1; req.add = 32'(32'h100 + k * 32);
            step();
            if (got_gnt) k++;
        end
        checki("bp_granted", k, 4);
        req.lrdy = 1'b1; npop = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            req.req = 1'b1; req.add = 32'(32'h100 + k * 32);
            step();
            if (popped) npop++;
            if (got_gnt) k++;
        end
        req.req = 1'b0;
        repeat (6) begin step(); if (popped) npop++; end
        checki("bp_fifth_granted", k, 5);
        checki("bp_responses", npop, 5);

        // read straddling the top of memory
        req = '0; req.req = 1'b1; req.wen = 1'b1; req.lrdy = 1'b1; req.add = 32'(MEMW * 4 - 8);
        step();
        req.req = 1'b0;
        step();
        check1("oor_opc", pop_opc, 1'b1);
        checkd("oor_hi_zero", pop_data >> 64, '0);
        req = '0; req.req = 1'b1; req.be = '1; req.lrdy = 1'b1; req.add = 32'(MEMW * 4 - 8);
        req.data = rnd_data();
        step();
        req.wen = 1'b1; req.be = '0;
        step();
        req.req = 1'b0;
        step(); step();

        // per-word byte offset
        req = '0; req.req = 1'b1; req.be = '1; req.lrdy = 1'b1;
        req.add = 32'h300; req.data = rnd_data();
        step();
        w2 = rnd_data();
        req.add = 32'h320; req.data = w2;
        step();
        req.wen = 1'b1; req.be = '0; req.add = 32'h300; req.boffs[3] = 8'd32;
        step();
        req.req = 1'b0;
        step();
        checkd("boffs_word3", pop_data[127:96], {{(DATA_W-32){1'b0}}, w2[127:96]});

        // random traffic with grant stalls and a mid-stream clear
        stall_en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            req.req  = ($urandom_range(0, 3) != 0);
            req.wen  = $urandom_range(0, 1);
            req.be   = $urandom;
            req.add  = ($urandom_range(0, 7) == 0) ? 32'(MEMW * 4 - 32 * $urandom_range(0, 2))
                                                   : 32'($urandom_range(0, 255) * 4);
            for (int i = 0; i < TCDM_NW; i++)
                req.boffs[i] = ($urandom_range(0, 7) == 0) ? 8'(4 * $urandom_range(0, 15)) : 8'd0;
            req.data = rnd_data();
            req.lrdy = ($urandom_range(0, 2) != 0);
            req.user = $urandom_range(0, 1);
            clear    = (c == 500);
            step();
            if (c == 500) begin
                clear = 1'b0;
                #1;
                check1("clear_r_valid", rsp.r_valid, 1'b0);
            end
        end
        stall_en = 1'b0;
        req.req = 1'b0; req.lrdy = 1'b1;
        repeat (8) step();
        check1("drain_idle", rsp.r_valid, 1'b0);

        // async reset with reads in flight
        req = '0; req.req = 1'b1; req.wen = 1'b1; req.lrdy = 1'b0;
        repeat (3) step();
        req.req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check1("arst_r_valid", rsp.r_valid, 1'b0);
        q.delete();
        lfsr = SEED;
        @(posedge clk); #1 rst_n = 1'b1;
        req.lrdy = 1'b1;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
